// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPE-CPU control path.
// Holds the opcode values, the alu_op codes consumed by alu_control,
// the datapath mux select codes and the main control FSM state encoding.
package cpu_defs_pkg;

    // Opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // alu_op codes shared with alu_control
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B input select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Main control FSM states; encodings are visible on state_w_o
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle CPE-CPU datapath.
// Sequences fetch/decode/execute/memory/writeback from the 6-bit opcode,
// stalls on mem_ready_w_i while a memory request is outstanding and traps
// (sticky until reset) on unsupported opcodes.
//
// Ports:
//   clk_w_i, rst_w_i        clock (rising edge), synchronous active-high reset
//   opcode_w_i              instr[31:26] from the instruction register
//   mem_ready_w_i           memory completes the current access this cycle
//   pc_write*, i_or_d, mem_read/write, ir_write, mem_to_reg, reg_write,
//   reg_dst, alu_src_a/b, alu_op, pc_source   datapath controls
//   trap_w_o                illegal opcode seen
//   state_w_o               current state for debug
module multicycle_control
    import cpu_defs_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk_w_i,
    input  logic                rst_w_i,
    input  logic [OPCODE_W-1:0] opcode_w_i,
    input  logic                mem_ready_w_i,
    output logic                pc_write_w_o,
    output logic                pc_write_cond_w_o,
    output logic                i_or_d_w_o,
    output logic                mem_read_w_o,
    output logic                mem_write_w_o,
    output logic                ir_write_w_o,
    output logic                mem_to_reg_w_o,
    output logic                reg_write_w_o,
    output logic                reg_dst_w_o,
    output logic                alu_src_a_w_o,
    output logic [1:0]          alu_src_b_w_o,
    output logic [1:0]          alu_op_w_o,
    output logic [1:0]          pc_source_w_o,
    output logic                trap_w_o,
    output logic [STATE_W-1:0]  state_w_o
);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk_w_i) begin
        if (rst_w_i) state <= S_FETCH;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (mem_ready_w_i) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode_w_i)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode_w_i == OP_LW)      state_next = S_MEM_RD;
                else if (opcode_w_i == OP_SW) state_next = S_MEM_WR;
                else                          state_next = S_TRAP;
            end
            S_MEM_RD:    if (mem_ready_w_i) state_next = S_MEM_WB;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WR:    if (mem_ready_w_i) state_next = S_FETCH;
            S_R_EXEC:    state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            S_TRAP:      state_next = S_TRAP;
            // Unused encodings recover into the trap state.
            default:     state_next = S_TRAP;
        endcase
    end

    always_comb begin
        pc_write_w_o      = 1'b0;
        pc_write_cond_w_o = 1'b0;
        i_or_d_w_o        = 1'b0;
        mem_read_w_o      = 1'b0;
        mem_write_w_o     = 1'b0;
        ir_write_w_o      = 1'b0;
        mem_to_reg_w_o    = 1'b0;
        reg_write_w_o     = 1'b0;
        reg_dst_w_o       = 1'b0;
        alu_src_a_w_o     = 1'b0;
        alu_src_b_w_o     = ALUB_REG;
        alu_op_w_o        = ALU_OP_ADD;
        pc_source_w_o     = PCSRC_ALU;
        trap_w_o          = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_w_o  = 1'b1;
                alu_src_b_w_o = ALUB_FOUR;
                // IR and PC load only in the cycle the fetch completes.
                ir_write_w_o  = mem_ready_w_i;
                pc_write_w_o  = mem_ready_w_i;
            end
            S_DECODE:    alu_src_b_w_o = ALUB_IMM_SH;
            S_MEM_ADDR: begin
                alu_src_a_w_o = 1'b1;
                alu_src_b_w_o = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_read_w_o = 1'b1;
                i_or_d_w_o   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_w_o  = 1'b1;
                mem_to_reg_w_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_w_o = 1'b1;
                i_or_d_w_o    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a_w_o = 1'b1;
                alu_op_w_o    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                reg_write_w_o = 1'b1;
                reg_dst_w_o   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_w_o     = 1'b1;
                alu_op_w_o        = ALU_OP_SUB;
                pc_write_cond_w_o = 1'b1;
                pc_source_w_o     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write_w_o  = 1'b1;
                pc_source_w_o = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                alu_src_a_w_o = 1'b1;
                alu_src_b_w_o = ALUB_IMM;
            end
            S_ADDI_WB:   reg_write_w_o = 1'b1;
            S_TRAP:      trap_w_o = 1'b1;
            default: ;
        endcase
        // Reset masks everything combinationally so no enable can fire in
        // the reset cycle, whatever state the register still holds.
        if (rst_w_i) begin
            pc_write_w_o      = 1'b0;
            pc_write_cond_w_o = 1'b0;
            i_or_d_w_o        = 1'b0;
            mem_read_w_o      = 1'b0;
            mem_write_w_o     = 1'b0;
            ir_write_w_o      = 1'b0;
            mem_to_reg_w_o    = 1'b0;
            reg_write_w_o     = 1'b0;
            reg_dst_w_o       = 1'b0;
            alu_src_a_w_o     = 1'b0;
            alu_src_b_w_o     = '0;
            alu_op_w_o        = '0;
            pc_source_w_o     = '0;
            trap_w_o          = 1'b0;
        end
    end

    assign state_w_o = rst_w_i ? '0 : STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, trap;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;
    logic [16:0] ctl_now;

    int total = 0;
    int bad   = 0;

    int          obs_st[$];
    int          exp_st[$];
    logic [16:0] obs_ctl[$];
    logic [16:0] exp_ctl[$];

    multicycle_control #(.OPCODE_W(6), .STATE_W(4)) dut (
        .clk_w_i           (clk),
        .rst_w_i           (rst),
        .opcode_w_i        (opcode),
        .mem_ready_w_i     (mem_ready),
        .pc_write_w_o      (pc_write),
        .pc_write_cond_w_o (pc_write_cond),
        .i_or_d_w_o        (i_or_d),
        .mem_read_w_o      (mem_read),
        .mem_write_w_o     (mem_write),
        .ir_write_w_o      (ir_write),
        .mem_to_reg_w_o    (mem_to_reg),
        .reg_write_w_o     (reg_write),
        .reg_dst_w_o       (reg_dst),
        .alu_src_a_w_o     (alu_src_a),
        .alu_src_b_w_o     (alu_src_b),
        .alu_op_w_o        (alu_op),
        .pc_source_w_o     (pc_source),
        .trap_w_o          (trap),
        .state_w_o         (state_o)
    );

    always #5 clk = ~clk;

    assign ctl_now = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
                      pc_source, trap};

    // Control word the datapath needs in each step of an instruction.
    function automatic logic [16:0] ctrl_of(input int st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, tr;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, tr} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: tr = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, asb, aop, psrc, tr};
    endfunction

    // Step sequence each instruction class walks through.
    task automatic recipe(input logic [5:0] op, output int q[$]);
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b000010: q = '{0, 1, 9};
            6'b001000: q = '{0, 1, 10, 11};
            default:   q = '{0, 1, 12};
        endcase
    endtask

    // Drives one instruction (fw fetch wait cycles, mw data wait cycles),
    // recording observed and expected per-cycle traces; stops after limit.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int limit);
        int  steps[$];
        int  nwait;
        bit  memst;
        obs_st.delete(); exp_st.delete(); obs_ctl.delete(); exp_ctl.delete();
        recipe(op, steps);
        foreach (steps[k]) begin
            memst = (steps[k] == 0) || (steps[k] == 3) || (steps[k] == 5);
            nwait = memst ? ((steps[k] == 0) ? fw : mw) : 0;
            for (int w = 0; w <= nwait; w++) begin
                if (obs_st.size() >= limit) return;
                mem_ready = memst ? (w == nwait) : 1'($urandom_range(0, 1));
                opcode    = (steps[k] == 0 && w < nwait) ? 6'($urandom) : op;
                @(negedge clk);
                obs_st.push_back(int'(state_o));
                obs_ctl.push_back(ctl_now);
                exp_st.push_back(steps[k]);
                exp_ctl.push_back(ctrl_of(steps[k], mem_ready));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (ctl_now !== 17'h0 || state_o !== 4'd0 || trap !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got ctl=%05h state=%0d trap=%b, want ctl=00000 state=0 trap=0",
                     ctl_now, state_o, trap);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'd0 || ctl_now !== ctrl_of(0, 1'b0)) begin
            bad++;
            $display("FAIL reset_fetch: got state=%0d ctl=%05h, want state=0 ctl=%05h",
                     state_o, ctl_now, ctrl_of(0, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        run_instr(6'b100011, 0, 0, 100);
        for (int i = 0; i < obs_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                bad++;
                $display("FAIL lw_step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL lw_return: got state=%0d, want 0", state_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype;
        run_instr(6'b000000, 0, 0, 100);
        for (int i = 0; i < obs_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                bad++;
                $display("FAIL rtype_step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL rtype_return: got state=%0d, want 0", state_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_stall;
        int wcount;
        run_instr(6'b101011, 0, 3, 100);
        wcount = 0;
        for (int i = 0; i < obs_st.size(); i++) begin
            if (obs_ctl[i][12]) wcount++;
            total++;
            if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                bad++;
                $display("FAIL sw_step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
            end
        end
        total++;
        if (wcount !== 4) begin
            bad++;
            $display("FAIL sw_write_cycles: got %0d, want 4", wcount);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL sw_return: got state=%0d, want 0", state_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_stall;
        int ircount;
        int irfirst;
        run_instr(6'b001000, 2, 0, 100);
        ircount = 0; irfirst = -1;
        for (int i = 0; i < obs_st.size(); i++) begin
            if (obs_ctl[i][11]) begin
                ircount++;
                if (irfirst < 0) irfirst = i;
            end
            total++;
            if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                bad++;
                $display("FAIL fetch_stall_step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
            end
        end
        total++;
        if (ircount !== 1 || irfirst !== 2) begin
            bad++;
            $display("FAIL fetch_stall_irwrite: got count=%0d first=%0d, want count=1 first=2",
                     ircount, irfirst);
        end
    endtask

    task automatic test_branch_jump;
        logic [5:0] ops [2];
        ops[0] = 6'b000100;
        ops[1] = 6'b000010;
        for (int n = 0; n < 2; n++) begin
            run_instr(ops[n], 0, 0, 100);
            for (int i = 0; i < obs_st.size(); i++) begin
                total++;
                if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                    bad++;
                    $display("FAIL branch_jump op=%b step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                             ops[n], i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [5:0] legal [6];
        logic [5:0] op;
        legal[0] = 6'b000000; legal[1] = 6'b100011; legal[2] = 6'b101011;
        legal[3] = 6'b000100; legal[4] = 6'b000010; legal[5] = 6'b001000;
        for (int n = 0; n < 25; n++) begin
            op = legal[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 100);
            for (int i = 0; i < obs_st.size(); i++) begin
                total++;
                if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i] ||
                    (obs_ctl[i][13] && obs_ctl[i][12])) begin
                    bad++;
                    $display("FAIL random#%0d op=%b step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                             n, op, i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        // Stop inside MEM_RD while the read is still waiting.
        run_instr(6'b100011, 0, 5, 5);
        for (int i = 0; i < obs_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                bad++;
                $display("FAIL reset_mid_step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
            end
        end
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_now !== 17'h0 || state_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got ctl=%05h state=%0d, want ctl=00000 state=0",
                     ctl_now, state_o);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'd0 || ctl_now !== ctrl_of(0, 1'b0)) begin
            bad++;
            $display("FAIL reset_mid_fetch: got state=%0d ctl=%05h, want state=0 ctl=%05h",
                     state_o, ctl_now, ctrl_of(0, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_trap;
        run_instr(6'b111111, 0, 0, 100);
        for (int i = 0; i < obs_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i]) begin
                bad++;
                $display("FAIL trap_step%0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom);
            @(negedge clk);
            total++;
            if (state_o !== 4'd12 || trap !== 1'b1 || ctl_now !== 17'h00001) begin
                bad++;
                $display("FAIL trap_sticky%0d: got state=%0d trap=%b ctl=%05h, want state=12 trap=1 ctl=00001",
                         i, state_o, trap, ctl_now);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (trap !== 1'b0 || ctl_now !== 17'h0) begin
            bad++;
            $display("FAIL trap_reset: got trap=%b ctl=%05h, want trap=0 ctl=00000", trap, ctl_now);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'd0 || trap !== 1'b0) begin
            bad++;
            $display("FAIL trap_exit: got state=%0d trap=%b, want state=0 trap=0", state_o, trap);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_stall();
        test_fetch_stall();
        test_branch_jump();
        test_random();
        test_reset_mid();
        test_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
